serial_maxpool2: RTL and testbench
==================================

Name: serial_maxpool2

Overview:
- Element-wise signed max of two multi-channel operands, each arriving bit-serially in SER_BW-bit chunks, LSB chunk first.
- Operand A arrives first, then operand B; the block emits one full-width parallel result word per channel.
- Sits after serialized conv/activation stages in the inference pipeline and performs 2:1 max pooling across all channels in parallel.

Parameters:
- NO_CH, 10, number of parallel channels.
- BW_IN, 4, full operand width in bits (two's complement); must be divisible by SER_BW.
- SER_BW, 2, serial chunk width per channel per cycle.
- Derived localparam CYC = BW_IN/SER_BW, the number of beats per operand.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low (asserted when 0).
- vld_in  input  1  current data_in chunk is valid.
- data_in  input  [NO_CH-1:0][SER_BW-1:0]  one chunk per channel.
- vld_out  output  1  one-cycle pulse; data_out holds a new result.
- data_out  output  [NO_CH-1:0][BW_IN-1:0]  per-channel signed max.

Behaviour:
- Reset (rst==0 at posedge): vld_out=0, data_out=0, beat counter=0, deserialize registers cleared. Reset mid-operation discards the partial pair.
- Each posedge with vld_in==1 is one beat. A beat counter runs 0..2*CYC-1 and wraps to 0 after the last beat.
- Beats 0..CYC-1 load operand A. Beat k supplies bits [k*SER_BW +: SER_BW] of each channel.
- Beats CYC..2*CYC-1 load operand B in the same way.
- vld_in==0 cycles are ignored: the counter and registers hold, so beats need not be contiguous.
- On the posedge that captures the final B beat, the block:
  - assembles full A and B per channel,
  - computes max = ($signed(A) > $signed(B)) ? A : B (ties select B),
  - registers the result into data_out.
- vld_out=1 in the cycle immediately following that edge. Latency is one clock after the last B chunk.
- vld_out is 0 in all other cycles. data_out holds its value until the next result is written.
- Back-to-back pairs are supported: a new A may start on the beat right after the final B beat, giving full throughput of one result per 2*CYC beats.
- Channels are fully independent, with no cross-channel interaction.
- An incremental MSB-last signed comparison that avoids full-width storage of B is permitted, provided the outputs are bit- and cycle-identical to the above.

Optional Feature:
- Macro SERIAL_MAXPOOL_RELU_EN.
- When defined, each channel result is clamped: a negative max (MSB=1) outputs 0. Timing and handshake are unchanged.
- When undefined, the plain signed max is output.

Decomposition:
- Package serial_maxpool_pkg holds:
  - default constants NO_CH, BW_IN, SER_BW,
  - the CYC derivation function,
  - typedef for the chunk vector [NO_CH-1:0][SER_BW-1:0],
  - typedef for the result vector [NO_CH-1:0][BW_IN-1:0].
- Sub-module serial_maxpool2_lane: one channel's A/B deserializer plus signed compare, replicated NO_CH times by generate.
- The top level owns the shared beat counter, vld_out, and the reset logic.

Test Plan:
- Basic: ch0 A=4'b0111 (chunks 11,01), B=4'b1000 (chunks 00,10) → ch0 out 0111; vld_out high exactly one cycle, 1 clock after beat 3.
- Negatives: A=4'b1110 (-2), B=4'b1001 (-7) → 1110. Equality: A=B=4'b0101 → 0101.
- All 10 channels with random values → every channel equals its signed max. Hold vld_in low 3 cycles between beats 1 and 2 → same result, vld_out delayed by exactly 3 cycles.
- Back-to-back: two pairs on 8 contiguous beats → two vld_out pulses 4 cycles apart, each with the correct data; data_out is stable between the pulses.
- Reset: drive rst=0 after beat 2, then rst=1 and a fresh pair → no vld_out from the aborted pair; the fresh pair gives the correct max; outputs are 0 while in reset.
- SERIAL_MAXPOOL_RELU_EN defined: A=-2, B=-7 → out 0000. A=3, B=-7 → out 0011.

Source files
------------

// File: rtl/serial_maxpool_pkg.sv
// serial_maxpool_pkg: shared constants, beat-count helper and vector types for serial_maxpool2
package serial_maxpool_pkg;
    localparam int NO_CH  = 10;
    localparam int BW_IN  = 4;
    localparam int SER_BW = 2;

    function automatic int cyc(input int bw_in, input int ser_bw);
        return bw_in / ser_bw;
    endfunction

    typedef logic [NO_CH-1:0][SER_BW-1:0] chunk_t;
    typedef logic [NO_CH-1:0][BW_IN-1:0]  result_t;
endpackage

// File: rtl/serial_maxpool2_lane.sv
// serial_maxpool2_lane: one channel's A/B deserializer and signed max; SERIAL_MAXPOOL_RELU_EN clamps negatives to 0
module serial_maxpool2_lane #(
    parameter int BW_IN  = 4,
    parameter int SER_BW = 2,
    parameter int CW     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vld,
    input  logic              i_sel_b,
    input  logic [CW-1:0]     i_idx,
    input  logic              i_last,
    input  logic [SER_BW-1:0] i_chunk,
    output logic [BW_IN-1:0]  o_max
);
    logic [BW_IN-1:0] r_a;
    logic [BW_IN-1:0] r_b;
    logic [BW_IN-1:0] r_max;
    logic [BW_IN-1:0] w_b;
    logic [BW_IN-1:0] w_max;

    // full B is the stored low chunks plus the MSB chunk arriving on the final beat
    always_comb begin
        w_b = r_b;
        w_b[BW_IN-SER_BW +: SER_BW] = i_chunk;
`ifdef SERIAL_MAXPOOL_RELU_EN
        w_max = ($signed(r_a) > $signed(w_b)) ? (r_a[BW_IN-1] ? '0 : r_a) : (w_b[BW_IN-1] ? '0 : w_b);
`else
        w_max = ($signed(r_a) > $signed(w_b)) ? r_a : w_b;
`endif
    end

    // deserialize each beat into A or B, and latch the result on the final B beat
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_max <= '0;
        end else if (i_vld) begin
            if (i_sel_b) r_b[int'(i_idx)*SER_BW +: SER_BW] <= i_chunk;
            else         r_a[int'(i_idx)*SER_BW +: SER_BW] <= i_chunk;
            if (i_last)  r_max <= w_max;
        end
    end

    assign o_max = r_max;
endmodule

// File: rtl/serial_maxpool2.sv
// serial_maxpool2: bit-serial 2:1 signed max pooling across NO_CH channels; SERIAL_MAXPOOL_RELU_EN enables ReLU clamp
module serial_maxpool2
    import serial_maxpool_pkg::*;
#(
    parameter int NO_CH  = serial_maxpool_pkg::NO_CH,
    parameter int BW_IN  = serial_maxpool_pkg::BW_IN,
    parameter int SER_BW = serial_maxpool_pkg::SER_BW
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         vld_in,
    input  logic [NO_CH-1:0][SER_BW-1:0] data_in,
    output logic                         vld_out,
    output logic [NO_CH-1:0][BW_IN-1:0]  data_out
);
    localparam int CYC = cyc(BW_IN, SER_BW);
    localparam int CW  = $clog2(2 * CYC);

    logic [CW-1:0] r_cnt;
    logic          r_vld;
    logic          w_last;
    logic          w_sel_b;
    logic [CW-1:0] w_idx;

    // decode beat counter into operand select, chunk index and final-beat flag
    always_comb begin
        w_last  = r_cnt == CW'(2 * CYC - 1);
        w_sel_b = r_cnt >= CW'(CYC);
        w_idx   = w_sel_b ? r_cnt - CW'(CYC) : r_cnt;
    end

    // shared beat counter and one-cycle result strobe
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
            r_vld <= 1'b0;
        end else begin
            r_vld <= vld_in && w_last;
            if (vld_in) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    assign vld_out = r_vld;

    for (genvar c = 0; c < NO_CH; c++) begin : g_lane
        serial_maxpool2_lane #(
            .BW_IN (BW_IN),
            .SER_BW(SER_BW),
            .CW    (CW)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .i_vld  (vld_in),
            .i_sel_b(w_sel_b),
            .i_idx  (w_idx),
            .i_last (w_last),
            .i_chunk(data_in[c]),
            .o_max  (data_out[c])
        );
    end
endmodule

// File: tb/tb_serial_maxpool2.sv
// tb_serial_maxpool2: randomized and directed checks of serial_maxpool2 against a max-of-integers model
module tb_serial_maxpool2;
    import serial_maxpool_pkg::*;

    localparam int CYC = cyc(BW_IN, SER_BW);

    logic    clk = 1'b0;
    logic    rst = 1'b0;
    logic    vld_in = 1'b0;
    chunk_t  data_in = '0;
    logic    vld_out;
    result_t data_out;

    int      n_cmp = 0;
    int      n_err = 0;
    result_t held = '0;

    serial_maxpool2 dut (
        .clk     (clk),
        .rst     (rst),
        .vld_in  (vld_in),
        .data_in (data_in),
        .vld_out (vld_out),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic result_t model(input result_t a, input result_t b);
        result_t r;
        r = '0;
        for (int c = 0; c < NO_CH; c++) begin
            int va;
            int vb;
            int m;
            va = $signed(a[c]);
            vb = $signed(b[c]);
            m  = (va > vb) ? va : vb;
`ifdef SERIAL_MAXPOOL_RELU_EN
            if (m < 0) m = 0;
`endif
            r[c] = m[BW_IN-1:0];
        end
        return r;
    endfunction

    function automatic result_t rnd_vec();
        result_t v;
        for (int c = 0; c < NO_CH; c++) v[c] = BW_IN'($urandom_range(0, (1 << BW_IN) - 1));
        return v;
    endfunction

    task automatic drive_beat(input result_t a, input result_t b, input int k);
        result_t op;
        op = (k < CYC) ? a : b;
        for (int c = 0; c < NO_CH; c++) data_in[c] = op[c][(k % CYC) * SER_BW +: SER_BW];
        vld_in = 1'b1;
        @(posedge clk);
        #1;
        vld_in  = 1'b0;
        data_in = chunk_t'($urandom());
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) begin
            @(posedge clk);
            #1;
            chk({tag, "_idle_vld"}, vld_out, 0);
            chk({tag, "_idle_hold"}, data_out, held);
        end
    endtask

    task automatic send_pair(input result_t a, input result_t b, input int gap_at, input int gap, input string tag);
        result_t e;
        e = model(a, b);
        for (int k = 0; k < 2 * CYC; k++) begin
            drive_beat(a, b, k);
            if (k == 2 * CYC - 1) begin
                chk({tag, "_pulse"}, vld_out, 1);
                chk({tag, "_data"}, data_out, e);
                held = e;
            end else begin
                chk({tag, "_novld"}, vld_out, 0);
                chk({tag, "_hold"}, data_out, held);
            end
            if (k == gap_at) idle(gap, tag);
        end
    endtask

    initial begin
        result_t a;
        result_t b;
        result_t a2;
        result_t b2;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_vld", vld_out, 0);
        chk("reset_data", data_out, 0);
        rst = 1'b1;
        idle(1, "post_reset");

        a = '0; b = '0; a[0] = 4'b0111; b[0] = 4'b1000;
        send_pair(a, b, -1, 0, "basic");
        idle(2, "basic");

        a = '0; b = '0; a[0] = 4'b1110; b[0] = 4'b1001;
        send_pair(a, b, -1, 0, "neg");
        idle(1, "neg");

        a = '0; b = '0; a[0] = 4'b0101; b[0] = 4'b0101;
        send_pair(a, b, -1, 0, "equal");
        idle(1, "equal");

        a = '0; b = '0; a[0] = 4'b0011; b[0] = 4'b1001;
        send_pair(a, b, -1, 0, "pos_neg");
        idle(1, "pos_neg");

        for (int i = 0; i < BW_IN * 4; i++) begin
            a = rnd_vec();
            b = rnd_vec();
            send_pair(a, b, int'($urandom_range(0, 2 * CYC - 1)), int'($urandom_range(0, 2)), "rand");
            idle(int'($urandom_range(0, 1)), "rand");
        end

        a = rnd_vec();
        b = rnd_vec();
        send_pair(a, b, 1, 3, "gap3");
        idle(1, "gap3");

        a  = rnd_vec(); b  = rnd_vec();
        a2 = rnd_vec(); b2 = rnd_vec();
        send_pair(a, b, -1, 0, "b2b_first");
        send_pair(a2, b2, -1, 0, "b2b_second");
        idle(2, "b2b");

        a = rnd_vec();
        b = rnd_vec();
        for (int k = 0; k < 3; k++) begin
            drive_beat(a, b, k);
            chk("abort_novld", vld_out, 0);
        end
        rst     = 1'b0;
        vld_in  = 1'b1;
        data_in = chunk_t'($urandom());
        @(posedge clk);
        #1;
        vld_in = 1'b0;
        held   = '0;
        chk("in_reset_vld", vld_out, 0);
        chk("in_reset_data", data_out, 0);
        @(posedge clk);
        #1;
        chk("in_reset_vld2", vld_out, 0);
        chk("in_reset_data2", data_out, 0);
        rst = 1'b1;
        a = rnd_vec();
        b = rnd_vec();
        send_pair(a, b, -1, 0, "fresh");
        idle(2, "fresh");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
